// File: rtl/bnn_pipe_engine.sv
// Two-layer XNOR-popcount binary neural network with a nibble-serial weight/threshold loader
// and a 2-stage inference pipeline. Optional layer-1 output tap: define BNN_L1_TAP_EN.
module bnn_pipe_engine #(
    parameter int IN_W = 8,
    parameter int N1   = 4,
    parameter int N2   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            load_en,
    input  logic [3:0]      load_nib,
    output logic            cfg_done,
    output logic [N2-1:0]   out_bits,
    output logic            out_valid
`ifdef BNN_L1_TAP_EN
    ,
    output logic [N1-1:0]   l1_bits
`endif
);

    localparam int          SW      = (IN_W > N1) ? IN_W : N1;
    localparam logic [4:0]  L1_WNIB = 5'(IN_W / 4);
    localparam logic [4:0]  L2_WNIB = 5'(N1 / 4);
    localparam logic [4:0]  L1_LAST = 5'(N1 - 1);
    localparam logic [4:0]  L2_LAST = 5'(N2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_L1,
        LOAD_L2
    } load_state_e;

    load_state_e state, state_next;

    logic [IN_W-1:0] w1  [N1];
    logic [7:0]      th1 [N1];
    logic [N1-1:0]   w2  [N2];
    logic [7:0]      th2 [N2];

    logic [4:0]      nib_cnt;
    logic [4:0]      nrn_cnt;
    logic [SW-1:0]   stage_w;
    logic [3:0]      stage_th_lo;

    logic            in_l2;
    logic [4:0]      w_nibs;
    logic            is_th_lo;
    logic            is_last_nib;
    logic            last_nrn;
    logic            commit;

    // In IDLE the counters are zero, so the first nibble decodes as L1 weight nibble 0.
    assign in_l2       = (state == LOAD_L2);
    assign w_nibs      = in_l2 ? L2_WNIB : L1_WNIB;
    assign is_th_lo    = (nib_cnt == w_nibs);
    assign is_last_nib = (nib_cnt == w_nibs + 5'd1);
    assign last_nrn    = in_l2 ? (nrn_cnt == L2_LAST) : (nrn_cnt == L1_LAST);
    assign commit      = load_en && is_last_nib;

    assign in_ready    = (state == IDLE) && !load_en;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_en)            state_next = LOAD_L1;
            LOAD_L1: if (commit && last_nrn) state_next = LOAD_L2;
            LOAD_L2: if (commit && last_nrn) state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // NOTE: the weight tables are flops with a defined reset value, so they are cleared here
    // rather than mapped to an unreset RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < N1; n++) begin
                w1[n]  <= '0;
                th1[n] <= 8'hFF;
            end
            for (int n = 0; n < N2; n++) begin
                w2[n]  <= '0;
                th2[n] <= 8'hFF;
            end
            nib_cnt     <= '0;
            nrn_cnt     <= '0;
            stage_w     <= '0;
            stage_th_lo <= '0;
            cfg_done    <= 1'b0;
        end else if (load_en) begin
            if (commit) begin
                nib_cnt <= '0;
                nrn_cnt <= last_nrn ? 5'd0 : nrn_cnt + 5'd1;
                if (in_l2) begin
                    for (int n = 0; n < N2; n++) begin
                        if (nrn_cnt == 5'(n)) begin
                            w2[n]  <= stage_w[N1-1:0];
                            th2[n] <= {load_nib, stage_th_lo};
                        end
                    end
                    if (last_nrn) begin
                        cfg_done <= 1'b1;
                    end
                end else begin
                    for (int n = 0; n < N1; n++) begin
                        if (nrn_cnt == 5'(n)) begin
                            w1[n]  <= stage_w[IN_W-1:0];
                            th1[n] <= {load_nib, stage_th_lo};
                        end
                    end
                end
            end else begin
                nib_cnt <= nib_cnt + 5'd1;
                if (is_th_lo) begin
                    stage_th_lo <= load_nib;
                end else begin
                    for (int k = 0; k < SW / 4; k++) begin
                        if (nib_cnt == 5'(k)) begin
                            stage_w[k*4 +: 4] <= load_nib;
                        end
                    end
                end
            end
        end
    end

    logic [N1-1:0] l1_next;
    logic [N2-1:0] l2_next;
    logic [N1-1:0] l1_q;
    logic [7:0]    pc1;
    logic [7:0]    pc2;
    logic          v1;
    logic          accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        l1_next = '0;
        pc1     = '0;
        for (int n = 0; n < N1; n++) begin
            pc1 = '0;
            for (int i = 0; i < IN_W; i++) begin
                pc1 = pc1 + 8'(in_data[i] == w1[n][i]);
            end
            l1_next[n] = (pc1 >= th1[n]);
        end
    end

    always_comb begin
        l2_next = '0;
        pc2     = '0;
        for (int n = 0; n < N2; n++) begin
            pc2 = '0;
            for (int i = 0; i < N1; i++) begin
                pc2 = pc2 + 8'(l1_q[i] == w2[n][i]);
            end
            l2_next[n] = (pc2 >= th2[n]);
        end
    end

    // Stage 2 only updates behind a valid stage-1 item, so out_bits holds between results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l1_q      <= '0;
            v1        <= 1'b0;
            out_bits  <= '0;
            out_valid <= 1'b0;
        end else begin
            v1        <= accept;
            out_valid <= v1;
            if (accept) begin
                l1_q <= l1_next;
            end
            if (v1) begin
                out_bits <= l2_next;
            end
        end
    end

`ifdef BNN_L1_TAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l1_bits <= '0;
        end else begin
            l1_bits <= l1_q;
        end
    end
`endif

endmodule

// File: doc/bnn_pipe_engine.md
# bnn_pipe_engine

Parametrised two-layer binary neural network engine. It is the successor to the fixed 8-input, 4+4-neuron XNOR-popcount core. It adds runtime-loadable weights and thresholds for both layers through a single nibble-serial configuration stream, with atomic per-neuron commit. Inference is a 2-stage registered pipeline with a valid/ready handshake, and the block sits between the tile's input pins and the output mux.

## Interface
- IN_W, 8: input vector width; multiple of 4, range 4..64
- N1, 4: layer-1 neuron count; multiple of 4, range 4..16
- N2, 4: layer-2 neuron count; range 1..16
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  IN_W  input vector, bit i = input i
- in_valid  input  1  in_data valid
- in_ready  output  1  engine accepts in_data this cycle
- load_en  input  1  load_nib valid this cycle
- load_nib  input  4  configuration nibble
- cfg_done  output  1  full table loaded since reset
- out_bits  output  N2  layer-2 neuron outputs, bit k = neuron k
- out_valid  output  1  out_bits updated this cycle

## Operation
- **Neuron function:** out = (popcount(x XNOR w) >= th).
  - Popcount is zero-extended to 8 bits and compared unsigned against the 8-bit threshold th.
  - th = 0 always fires; th > fan-in never fires.
- **Layer-1 neurons:** fan-in IN_W, x = in_data.
- **Layer-2 neurons:** fan-in N1, x = the layer-1 output vector.
- **Reset values:**
  - All weights 0, all thresholds 8'hFF.
  - out_bits 0, out_valid 0, cfg_done 0, in_ready 1.
  - Load FSM in IDLE, all counters 0.
- **Configuration stream:** one nibble is accepted per cycle with load_en = 1.
  - Record order: L1 neuron 0..N1-1, then L2 neuron 0..N2-1.
  - L1 record: IN_W/4 weight nibbles, least-significant nibble first, then threshold low nibble, then threshold high nibble.
  - L2 record: N1/4 weight nibbles, then the same two threshold nibbles.
- **Staging and commit:** nibbles accumulate in a staging register. Live weights and threshold for a neuron are written in a single cycle, on the clock edge that accepts the record's final nibble.
- **Load FSM states:**
  - IDLE --load_en--> LOAD_L1. The first nibble is consumed on this edge.
  - LOAD_L1 --last nibble of L1 record N1-1--> LOAD_L2.
  - LOAD_L2 --last nibble of L2 record N2-1--> IDLE, and cfg_done is set to 1 on that edge.
  - load_en = 0 in LOAD_L1/LOAD_L2 holds all counters and staging; gaps are unlimited.
- **Reloads:** a reload always rewrites the whole table. cfg_done stays 1 during reloads.
- **Input acceptance:** in_ready = (state == IDLE) && !load_en. A load start on the same cycle as in_valid wins, and the input is not accepted.
- **In-flight items:** at most 2 items are in flight. The earliest commit occurs 3 or more cycles after the FSM leaves IDLE, and L1 commits precede L2 commits. Therefore every accepted item completes using a single consistent weight set.
- **Mid-operation reset:** reset while loading discards partial records and returns all state, including weights already committed, to reset values.

## Timing
- Throughput is 1 vector per cycle while in_ready = 1.
- Handshake at edge t (in_valid & in_ready):
  - Stage-1 register captures the layer-1 outputs at t.
  - Stage-2 captures out_bits at t+1.
  - out_valid = 1 for exactly the cycle following t+1 (latency 2).
- out_valid is 0 when there is no accepted input 2 cycles earlier. out_bits holds its last value.
- Configuration: a full table takes N1*(IN_W/4+2) + N2*(N1/4+2) accepted nibbles. With defaults this is 16 + 12 = 28.
- cfg_done and in_ready rise on the edge of the last nibble. With load_en = 0 on the next cycle, that cycle has in_ready = 1.

## Configuration
- BNN_L1_TAP_EN defined:
  - Adds output l1_bits [N1-1:0], the stage-1 register delayed one cycle so it is aligned with out_bits.
  - l1_bits resets to 0.
- BNN_L1_TAP_EN undefined: no port and no extra registers; behaviour is otherwise identical.

## Test plan
- **Reset state:** reset pulse, then in_data = 8'hF0, in_valid = 1 for one cycle.
  - Required: out_valid pulses 2 cycles later with out_bits = 4'h0 (thresholds 8'hFF); cfg_done = 0.
- **Full load:**
  - Stream 28 nibbles. L1 weights F0, 0F, 3C, C3, all thresholds 5. L2 weights 1, E, 0, F with thresholds 4, 1, 3, 2.
  - Then apply in_data = 8'hF0.
  - Required: out_bits = 4'h5 after 2 cycles; l1_bits = 4'h1 if BNN_L1_TAP_EN is defined; cfg_done = 1 after nibble 28.
- **Back-to-back inputs:** F0, 0F, FF, 00 on consecutive cycles after the full load.
  - Required: four consecutive out_valid cycles in the same order, with no bubbles.
- **Load gaps:** insert random load_en = 0 gaps of 1..5 cycles in the stream.
  - Required: identical results to the gap-free load; in_ready = 0 from the first nibble until the last.
- **Collision:** in_valid = 1 on the same cycle as the first load_en.
  - Required: input not accepted (in_ready = 0); no out_valid is produced for it.
- **Mid-load reset:** assert reset after nibble 10 of a reload.
  - Required: weights return to 0, thresholds to FF, cfg_done = 0. A subsequent input yields out_bits = 0.
